// File: rtl/route_reserve_arbiter_pkg.sv
// Shared types and sizing helpers for the output-port route reservation
// arbiter and its round-robin picker.
package route_reserve_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01
   } arbState_t;

   function automatic int reqBusWidth(input int ports, input int reqWidth);
      return ports * reqWidth;
   endfunction

   function automatic int selWidth(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/route_reserve_arbiter_if.sv
// Reservation request / grant / crossbar-select bundle between the
// input-port head buffers and one output-port arbiter.
interface route_reserve_arbiter_if
   import route_reserve_arbiter_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int REQUEST_WIDTH = 2
);
   localparam int SEL_W = selWidth(PORTS);
   localparam int BUS_W = reqBusWidth(PORTS, REQUEST_WIDTH);

   logic [PORTS-1:0] routeReserveRequestValid;
   logic [BUS_W-1:0] routeReserveRequest;
   logic [PORTS-1:0] tailRelease;
   logic [PORTS-1:0] routeReserveStatus;
   logic [SEL_W-1:0] outSelect;
   logic             outSelectValid;
   logic             busy;

   modport master (
      output routeReserveRequestValid, routeReserveRequest, tailRelease,
      input  routeReserveStatus, outSelect, outSelectValid, busy
   );

   modport slave (
      input  routeReserveRequestValid, routeReserveRequest, tailRelease,
      output routeReserveStatus, outSelect, outSelectValid, busy
   );

endinterface

// File: rtl/route_reserve_arbiter_picker.sv
// Combinational round-robin picker: first set bit of match at or above
// ptr, wrapping past PORTS-1 back to 0.
module rr_priority_picker
   import route_reserve_arbiter_pkg::*;
#(
   parameter int PORTS = 4,
   localparam int SEL_W = selWidth(PORTS)
) (
   input  logic [PORTS-1:0] match,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             anyValid
);

   logic [SEL_W:0]   sum;
   logic [SEL_W-1:0] idx;

   // Scan farthest-first so the nearest candidate is the last assignment.
   always_comb begin
      winner   = '0;
      anyValid = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (SEL_W + 1)'(k);
         if (sum >= (SEL_W + 1)'(PORTS)) begin
            sum = sum - (SEL_W + 1)'(PORTS);
         end
         idx = sum[SEL_W-1:0];
         if (match[idx]) begin
            winner   = idx;
            anyValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/route_reserve_arbiter.sv
// Per-output route reservation arbiter: round-robin grant, then holds the
// crossbar select until the owner's tail flit passes.
module route_reserve_arbiter
   import route_reserve_arbiter_pkg::*;
#(
   parameter int PORTS = 4,
   parameter int REQUEST_WIDTH = 2,
   parameter int OUT_INDEX = 0
) (
   input  logic clk,
   input  logic rst,
   route_reserve_arbiter_if.slave bus
);

   localparam int SEL_W = selWidth(PORTS);

   arbState_t        state, stateNext;
   logic [SEL_W-1:0] ptr, ptrNext;
   logic [SEL_W-1:0] outSel, outSelNext;
   logic [SEL_W-1:0] winner;
   logic [PORTS-1:0] match;
   logic [PORTS-1:0] status, statusNext;
   logic             selValid, selValidNext;
   logic             anyValid;

   always_comb begin
      match = '0;
      for (int p = 0; p < PORTS; p++) begin
         match[p] = bus.routeReserveRequestValid[p] &&
            (bus.routeReserveRequest[p*REQUEST_WIDTH +: REQUEST_WIDTH]
             == REQUEST_WIDTH'(OUT_INDEX));
      end
   end

   rr_priority_picker #(.PORTS(PORTS)) picker (
      .match    (match),
      .ptr      (ptr),
      .winner   (winner),
      .anyValid (anyValid)
   );

   always_comb begin
      stateNext    = state;
      ptrNext      = ptr;
      outSelNext   = outSel;
      selValidNext = selValid;
      statusNext   = '0;
      unique case (state)
         IDLE: begin
            if (anyValid) begin
               stateNext    = HOLD;
               outSelNext   = winner;
               selValidNext = 1'b1;
               statusNext   = PORTS'(1) << winner;
            end
         end
         HOLD: begin
            if (bus.tailRelease[outSel]) begin
               stateNext    = IDLE;
               outSelNext   = '0;
               selValidNext = 1'b0;
               ptrNext      = (outSel == SEL_W'(PORTS - 1)) ?
                              '0 : outSel + 1'b1;
            end
         end
         default: begin
            stateNext    = IDLE;
            outSelNext   = '0;
            selValidNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         outSel   <= '0;
         selValid <= 1'b0;
         status   <= '0;
      end else begin
         state    <= stateNext;
         ptr      <= ptrNext;
         outSel   <= outSelNext;
         selValid <= selValidNext;
         status   <= statusNext;
      end
   end

   assign bus.routeReserveStatus = status;
   assign bus.outSelect          = outSel;
   assign bus.outSelectValid     = selValid;
   assign bus.busy               = selValid;

endmodule

// File: tb/tb_route_reserve_arbiter.sv
// Directed and randomized checks of route_reserve_arbiter against a
// packet-level ownership model.
module tb_route_reserve_arbiter;

   localparam int PORTS = 4;
   localparam int RW    = 2;
   localparam int OUT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   route_reserve_arbiter_if #(.PORTS(PORTS), .REQUEST_WIDTH(RW)) bus ();

   route_reserve_arbiter #(
      .PORTS(PORTS), .REQUEST_WIDTH(RW), .OUT_INDEX(OUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   // Reference: who owns the output, where the search starts, who got a pulse.
   int owner = -1;
   int ptr   = 0;
   int pulse = -1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int reqOf(input int p);
      return int'((bus.routeReserveRequest >> (p * RW)) & 2'b11);
   endfunction

   task automatic modelStep();
      pulse = -1;
      if (!rst) begin
         owner = -1;
         ptr   = 0;
      end else if (owner < 0) begin
         for (int k = 0; k < PORTS; k++) begin
            int p;
            p = (ptr + k) % PORTS;
            if (bus.routeReserveRequestValid[p] && reqOf(p) == OUT) begin
               owner = p;
               pulse = p;
               break;
            end
         end
      end else if (bus.tailRelease[owner]) begin
         ptr   = (owner + 1) % PORTS;
         owner = -1;
      end
   endtask

   task automatic cycle();
      modelStep();
      @(posedge clk);
      #1;
      chk("status", 32'(bus.routeReserveStatus),
          pulse < 0 ? 32'd0 : (32'd1 << pulse));
      chk("selValid", 32'(bus.outSelectValid), owner >= 0 ? 32'd1 : 32'd0);
      chk("busy", 32'(bus.busy), owner >= 0 ? 32'd1 : 32'd0);
      chk("outSelect", 32'(bus.outSelect), owner >= 0 ? 32'(owner) : 32'd0);
   endtask

   task automatic setReq(input int p, input logic v, input logic [1:0] r);
      bus.routeReserveRequestValid[p]    = v;
      bus.routeReserveRequest[p*RW +: RW] = r;
   endtask

   task automatic clearAll();
      bus.routeReserveRequestValid = '0;
      bus.routeReserveRequest      = '0;
      bus.tailRelease              = '0;
   endtask

   function automatic int decode(input logic [PORTS-1:0] v);
      int w;
      w = -1;
      for (int k = 0; k < PORTS; k++) if (v[k]) w = k;
      return w;
   endfunction

   int order[$];
   int rrExp[5] = '{0, 1, 2, 3, 0};
   int w;
   int waitC;

   initial begin
      clearAll();
      // Reset held with everyone requesting this output.
      rst = 1'b0;
      for (int p = 0; p < PORTS; p++) setReq(p, 1'b1, 2'(OUT));
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      chk("rst_first_grant", 32'(bus.routeReserveStatus), 32'b0001);
      clearAll();
      bus.tailRelease[0] = 1'b1;
      cycle();
      bus.tailRelease = '0;
      cycle();

      // Single request from port 1.
      setReq(1, 1'b1, 2'(OUT));
      cycle();
      chk("single_grant", 32'(bus.routeReserveStatus), 32'b0010);
      setReq(1, 1'b0, 2'(OUT));
      repeat (2) cycle();
      bus.tailRelease[1] = 1'b1;
      cycle();
      chk("single_release", 32'(bus.outSelectValid), 32'd0);
      bus.tailRelease = '0;
      cycle();

      // Port 3 asks for another output; port 0 asks for this one.
      setReq(3, 1'b1, 2'd1);
      setReq(0, 1'b1, 2'(OUT));
      cycle();
      chk("mismatch_grant0", 32'(bus.routeReserveStatus), 32'b0001);
      setReq(0, 1'b0, 2'(OUT));
      bus.tailRelease[0] = 1'b1;
      cycle();
      bus.tailRelease = '0;
      repeat (3) cycle();
      chk("mismatch_never", 32'(bus.routeReserveStatus), 32'd0);
      clearAll();

      // Round robin from a fresh pointer with all ports requesting.
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      for (int p = 0; p < PORTS; p++) setReq(p, 1'b1, 2'(OUT));
      for (int n = 0; n < 5; n++) begin
         waitC = 0;
         while (bus.routeReserveStatus == '0 && waitC < 8) begin
            cycle();
            waitC++;
         end
         chk("rr_wait", 32'(bus.routeReserveStatus != '0), 32'd1);
         w = decode(bus.routeReserveStatus);
         order.push_back(w);
         repeat (2) cycle();
         if (n < 4 && w >= 0) begin
            bus.tailRelease[w] = 1'b1;
            cycle();
            bus.tailRelease = '0;
         end
      end
      for (int n = 0; n < 5; n++) chk("rr_order", 32'(order[n]), 32'(rrExp[n]));
      clearAll();
      bus.tailRelease[0] = 1'b1;
      cycle();
      bus.tailRelease = '0;
      cycle();

      // Foreign tailRelease ignored while port 2 owns the output.
      setReq(2, 1'b1, 2'(OUT));
      cycle();
      chk("own2_grant", 32'(bus.routeReserveStatus), 32'b0100);
      setReq(2, 1'b0, 2'(OUT));
      bus.tailRelease[0] = 1'b1;
      cycle();
      chk("foreign_tail_hold", 32'(bus.outSelectValid), 32'd1);
      chk("foreign_tail_sel", 32'(bus.outSelect), 32'd2);
      bus.tailRelease = '0;
      bus.tailRelease[2] = 1'b1;
      cycle();
      bus.tailRelease = '0;
      cycle();

      // Single-flit packet: tail in the grant-pulse cycle.
      setReq(2, 1'b1, 2'(OUT));
      cycle();
      chk("sf_grant", 32'(bus.routeReserveStatus), 32'b0100);
      setReq(2, 1'b0, 2'(OUT));
      bus.tailRelease[2] = 1'b1;
      cycle();
      chk("sf_release", 32'(bus.outSelectValid), 32'd0);
      bus.tailRelease = '0;
      setReq(0, 1'b1, 2'(OUT));
      setReq(3, 1'b1, 2'(OUT));
      cycle();
      chk("sf_ptr3", 32'(bus.routeReserveStatus), 32'b1000);
      clearAll();
      bus.tailRelease[3] = 1'b1;
      cycle();
      bus.tailRelease = '0;
      cycle();

      // Reset in the middle of a reservation.
      setReq(1, 1'b1, 2'(OUT));
      setReq(3, 1'b1, 2'(OUT));
      cycle();
      chk("mid_grant1", 32'(bus.routeReserveStatus), 32'b0010);
      setReq(1, 1'b0, 2'(OUT));
      cycle();
      rst = 1'b0;
      cycle();
      chk("mid_rst_drop", 32'(bus.outSelectValid), 32'd0);
      rst = 1'b1;
      waitC = 0;
      while (bus.routeReserveStatus == '0 && waitC < 4) begin
         cycle();
         waitC++;
      end
      chk("mid_regrant3", 32'(bus.routeReserveStatus), 32'b1000);
      clearAll();
      bus.tailRelease[3] = 1'b1;
      cycle();
      bus.tailRelease = '0;

      // Random traffic, occasional reset.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) != 0);
         for (int p = 0; p < PORTS; p++) begin
            setReq(p, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? 2'(OUT)
                                              : 2'($urandom_range(0, 3)));
            bus.tailRelease[p] = ($urandom_range(0, 3) == 0);
         end
         cycle();
      end
      rst = 1'b1;
      clearAll();
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/route_reserve_arbiter.md
Name: route_reserve_arbiter

Overview:
- One instance per router output port, directly downstream of the per-input-port head flit buffers.
- Collects route reservation requests (valid plus encoded destination port) from all input ports. Grants the output to one matching requester using round-robin, and returns a one-cycle routeReserveStatus pulse to the winner.
- Holds the crossbar select for that output until the winner's tail flit has passed, then releases the output.

Parameters:
- PORTS, 4, number of router input ports competing for this output.
- REQUEST_WIDTH, 2, width of each encoded route request; must satisfy 2**REQUEST_WIDTH >= PORTS.
- OUT_INDEX, 0, encoded output-port id this arbiter serves; a request matches when its value equals OUT_INDEX.

Ports:
- clk, input, 1, the single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-low reset.
- routeReserveRequestValid, input, PORTS, per-input request valid; held high by the source until granted.
- routeReserveRequest, input, PORTS*REQUEST_WIDTH, flat request bus; port p occupies bits [p*REQUEST_WIDTH +: REQUEST_WIDTH].
- tailRelease, input, PORTS, per-input one-cycle pulse: the tail flit of the current packet handshaked through the switch.
- routeReserveStatus, output, PORTS, one-hot grant pulse to the winning input port.
- outSelect, output, $clog2(PORTS), index of the input port currently owning this output (crossbar mux select).
- outSelectValid, output, 1, high while the output is reserved.
- busy, output, 1, equals outSelectValid; exported for switch-level status.

Behaviour:
- Reset (rst==0 at an edge) forces the following: state=IDLE, routeReserveStatus=0, outSelect=0, outSelectValid=0, priority pointer=0. Reset wins over every other event, including mid-HOLD; any in-progress reservation is dropped.
- Match vector: match[p] = routeReserveRequestValid[p] && (request slice p == OUT_INDEX).
- States are IDLE and HOLD (2-bit encoding from the package).
- IDLE, match==0: remain in IDLE; all outputs low.
- IDLE, match!=0: the winner g is the first set bit of match searching from ptr upward, wrapping at PORTS-1 back to 0. Next edge: state=HOLD, outSelect=g, outSelectValid=1, routeReserveStatus=onehot(g).
- Latency: request visible in cycle t produces a grant pulse in cycle t+1.
- routeReserveStatus is high for exactly one cycle (the first HOLD cycle), then 0. It is never asserted in IDLE, and never to more than one port.
- HOLD: outSelect and outSelectValid are stable. New matches are ignored and those sources keep waiting.
- HOLD exit: when tailRelease[outSelect]==1 (any HOLD cycle, including the grant-pulse cycle for single-flit packets), the next edge gives state=IDLE, outSelectValid=0, ptr=(outSelect+1) mod PORTS.
- tailRelease from non-owner ports is ignored in all states. tailRelease in IDLE is ignored.
- Re-arbitration: on release there is one IDLE cycle, so a pending request is granted at release edge +2. There is no back-to-back grant without an IDLE cycle.
- Fairness: after a grant, the pointer moves past the winner. With all PORTS requesting continuously, each port is granted once per PORTS grants.
- The pointer updates only on release, never on grant.
- Combinational outputs: none. All outputs come straight from flops.
- Top-level wiring:
  - The per-input routeReserveStatus seen by a head flit buffer is the OR over all output arbiters; at most one can pulse for a given input, since each input requests exactly one output.
  - The source must deassert its request valid by the cycle after the pulse; the arbiter does not depend on this while in HOLD.

Decomposition:
- Shared package: the IDLE/HOLD state encoding, and the request-slice width helper function.
- One combinational sub-module, rr_priority_picker (inputs: match vector and pointer; outputs: winner index and any_valid). It is reused by future VC allocators.
- The arbiter instantiates one rr_priority_picker and owns the state, pointer and output flops.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all requests active -> routeReserveStatus=0, outSelectValid=0, outSelect=0 throughout. First grant after release of reset goes to port 0 when ports 0–3 all request OUT_INDEX.
- Single request: OUT_INDEX=2, port 1 requests 2 at cycle 5 -> routeReserveStatus=4'b0010 only at cycle 6, outSelect=1 with outSelectValid=1 from cycle 6. tailRelease[1] at cycle 9 -> outSelectValid=0 at cycle 10.
- Mismatch filter: port 3 requests value 1 while OUT_INDEX=2 -> no grant ever; concurrent port 0 requesting 2 is granted at the next cycle.
- Round-robin: all 4 ports request OUT_INDEX continuously, with each tail 2 cycles after its grant -> grant order 0,1,2,3,0. Each grant pulse is exactly 1 cycle, separated by the release cycle plus 1 IDLE cycle.
- Release filtering and single-flit packets:
  - During port 2 ownership, tailRelease[0] pulses -> reservation held.
  - tailRelease[2] in the same cycle as the grant pulse -> IDLE next cycle, ptr=3.
- Reset mid-HOLD: port 1 owns the output, rst=0 for one cycle -> outSelectValid=0 and ptr=0 next cycle. A still-pending port 3 request is re-granted 2 cycles after reset deasserts.
